fifo_reader: RTL

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_rd_skid.sv | 59 +++++
 rtl/fifo_reader.sv | 97 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the FIFO burst reader.
//   state_t     - burst controller states (IDLE / READ / FLUSH)
//   DATA_W_DEF  - default FIFO/stream data width
//   LEN_W_DEF   - default burst length / counter width
package fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry FIFO-order output buffer for the burst reader.
//   clk, rst_n - clock, synchronous active-low reset
//   wr, wdata  - write one word (caller guarantees space)
//   rd         - pop the head word (ignored when empty)
//   valid      - buffer holds at least one word
//   data       - head word
//   occ        - current occupancy (0..2)
module fifo_rd_skid #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [1:0]        occ
);

    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tail;
    logic              rd_ok;

    assign rd_ok = rd && (occ != 2'd0);
    assign valid = (occ != 2'd0);
    assign data  = head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            occ  <= 2'd0;
        end else begin
            case ({wr, rd_ok})
                2'b10: begin
                    if (occ == 2'd0) head <= wdata;
                    else             tail <= wdata;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // Pop and write together: occupancy unchanged, order kept.
                    if (occ == 2'd1) begin
                        head <= wdata;
                    end else begin
                        head <= tail;
                        tail <= wdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: reads a burst of len words from a FIFO and streams them out
// over a valid/ready interface, with read issue throttled so the 2-entry
// output buffer can never overflow.
//   clk, rst_n      - clock, synchronous active-low reset
//   start, len      - burst request pulse and word count (0 = no burst)
//   busy, done      - burst active / last word accepted pulse
//   ren, empty,dout - FIFO read port (dout valid the cycle after ren)
//   m_valid, m_ready, m_data - output stream
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              ren,
    input  logic              empty,
    input  logic [DATA_W-1:0] dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data
);

    state_t            state;
    logic [LEN_W-1:0]  issue_cnt;
    logic [LEN_W-1:0]  deliver_cnt;
    logic              inflight;
    logic [1:0]        occ;
    logic              buf_valid;
    logic [DATA_W-1:0] buf_data;
    logic              pop;
    logic              credit_ok;

    // Outputs are forced quiet while reset is held so nothing leaks during
    // the reset cycle itself.
    assign m_valid = rst_n && buf_valid;
    assign m_data  = rst_n ? buf_data : '0;
    assign pop     = m_valid && m_ready;
    assign busy    = (state != ST_IDLE);

    // credit = 2 - occ - inflight + pop > 0, kept unsigned.
    assign credit_ok = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

    assign ren  = rst_n && (state == ST_READ) && (issue_cnt != '0) && !empty && credit_ok;
    assign done = pop && (state != ST_IDLE) && (deliver_cnt == LEN_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            issue_cnt   <= '0;
            deliver_cnt <= '0;
            inflight    <= 1'b0;
        end else begin
            inflight <= ren;

            case (state)
                ST_IDLE: begin
                    if (start && (len != '0)) begin
                        state       <= ST_READ;
                        issue_cnt   <= len;
                        deliver_cnt <= len;
                    end
                end
                ST_READ: begin
                    if (ren) begin
                        issue_cnt <= issue_cnt - LEN_W'(1);
                        if (issue_cnt == LEN_W'(1)) state <= ST_FLUSH;
                    end
                end
                default: ;
            endcase

            if (pop && (state != ST_IDLE) && (deliver_cnt != '0))
                deliver_cnt <= deliver_cnt - LEN_W'(1);

            // Last word accepted: burst over regardless of current state.
            if (done) state <= ST_IDLE;
        end
    end

    fifo_rd_skid #(.DATA_W(DATA_W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (inflight),
        .wdata (dout),
        .rd    (pop),
        .valid (buf_valid),
        .data  (buf_data),
        .occ   (occ)
    );

endmodule
